// File: rtl/multibyte_serial_adder.sv
// multibyte_serial_adder: byte-serial wide unsigned adder, LSB byte first, valid/ready on both sides
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake; a, b captured only on the accepting edge
//   out_valid/out_ready   : result handshake; sum, carry_out valid while out_valid=1
//   busy                  : high while adding or holding a result
//   overflow              : signed overflow of the result, present only with SERIAL_ADD_OVERFLOW_EN
module multibyte_serial_adder #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  carry_out,
   output logic                  busy
`ifdef SERIAL_ADD_OVERFLOW_EN
   ,output logic                 overflow
`endif
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic carry_q, carry_d, cout_q, cout_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [8:0] add;
`ifdef SERIAL_ADD_OVERFLOW_EN
   logic ovf_q, ovf_d;
   assign overflow = ovf_q;
`endif
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign sum       = sum_q;
   assign carry_out = cout_q;
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      add = {1'b0, a_q[8*idx_q +: 8]} + {1'b0, b_q[8*idx_q +: 8]} + {8'd0, carry_q};
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = 1'b0;
            idx_d   = '0;
            state_d = ADD;
         end
         ADD: begin
            sum_d[8*idx_q +: 8] = add[7:0];
            carry_d = add[8];
            idx_d   = idx_q + IW'(1);
            if (idx_q == IW'(NBYTES - 1)) begin
               idx_d   = '0;
               cout_d  = add[8];
               state_d = DONE;
`ifdef SERIAL_ADD_OVERFLOW_EN
               // carry into the MSB is recovered as a^b^s at bit W-1
               ovf_d = a_q[W-1] ^ b_q[W-1] ^ add[7] ^ add[8];
`endif
            end
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
`ifdef SERIAL_ADD_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
`ifdef SERIAL_ADD_OVERFLOW_EN
         ovf_q   <= ovf_d;
`endif
      end
   end
endmodule

// File: doc/multibyte_serial_adder.md
Name: multibyte_serial_adder

Overview:
Multi-cycle adder for wide unsigned operands. It processes one byte per clock, least-significant byte first, and chains the carry between bytes through a register. It sits upstream of any consumer that needs wide sums and uses a valid/ready handshake on both sides. It reuses the team's byte-wide ripple add concept, extended with a carry-in.

Parameters:
NBYTES, 4, operand width in bytes (legal range 1..16); operand width W = 8*NBYTES.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a/b present
in_ready  output  1  block can accept operands
a  input  W  operand A (unsigned)
b  input  W  operand B (unsigned)
out_valid  output  1  sum/carry_out valid
out_ready  input  1  consumer accepts result
sum  output  W  A+B modulo 2^W
carry_out  output  1  carry out of bit W-1
busy  output  1  high in ADD or DONE

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0, internal byte index=0, carry register=0.
- States:
  - IDLE: in_ready=1. If in_valid=1 at a clock edge, latch a and b into internal registers, clear the carry register to 0 and the index to 0, and go to ADD.
  - ADD: in_ready=0, busy=1. Each cycle compute {c,s} = a_byte[idx] + b_byte[idx] + carry_reg as a 9-bit result. Write s to sum[8*idx+7:8*idx] and c to carry_reg. If idx == NBYTES-1, go to DONE; otherwise idx increments.
  - DONE: out_valid=1, carry_out=carry_reg, and sum is stable. Hold until out_ready=1 at a clock edge, then go to IDLE with out_valid=0 on the next cycle.
- Latency: with in_valid accepted at edge N, out_valid is first high after edge N+NBYTES.
- Throughput: at most one operation per NBYTES+2 cycles.
- Operand capture: a and b are sampled only on the accepting edge. Input changes during ADD or DONE have no effect.
- Result hold: sum and carry_out keep their last values in IDLE until the next operation starts writing. They are only meaningful while out_valid=1.
- No overlap: in_ready is low in DONE, so a new operation cannot start in the same cycle the result is consumed.
- in_valid while busy: ignored; the upstream must hold it until in_ready=1.
- Reset mid-operation (ADD or DONE): returns to IDLE with reset values on the next edge. The partial result is discarded and no out_valid is issued.
- NBYTES=1: ADD lasts exactly one cycle.
- Wrap-around: the sum is modulo 2^W. Any overflow is reported only through carry_out (and overflow, if enabled).

Optional Feature:
- Macro: SERIAL_ADD_OVERFLOW_EN.
- With the macro defined: an extra port, overflow output 1 bit, is present. It reflects two's-complement signed overflow: the carry into bit W-1 XOR carry_out. It is captured during the final ADD cycle, valid while out_valid=1, and reset to 0.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- NBYTES=4, a=0x000000FF, b=0x00000001, in_valid pulse, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x00000100, carry_out=0.
- a=0xFFFFFFFF, b=0x00000001 → sum=0x00000000, carry_out=1. With SERIAL_ADD_OVERFLOW_EN, overflow=0.
- a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, carry_out=0. With SERIAL_ADD_OVERFLOW_EN, overflow=1.
- Backpressure: a=0x0F0F0F0F, b=0x21212121, out_ready held 0 for 6 cycles after out_valid rises → sum=0x30303030 and out_valid stay stable, in_ready=0 throughout. out_valid falls one cycle after out_ready=1, and in_ready returns to 1.
- Reset mid-op: accept a=0x12345678, b=0x11111111, assert rst during the 2nd ADD cycle → next cycle state=IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0. No out_valid ever appears for that operation.
- Back-to-back: in_valid held high with two operand pairs (3+4, then 0xFFFFFFFE+0x00000003) → results are 7/carry 0, then 0x00000001/carry 1, in order. The second operation is accepted only when in_ready=1, spaced NBYTES+2 cycles apart.
